clk_meas_multi: RTL and testbench
=================================

# clk_meas_multi

Multi-channel reference-clock frequency meter for board bring-up. Counts rising edges of up to 8 asynchronous, pre-divided clock-indicator inputs over a programmable gate window timed by the system clock, and publishes per-channel counts through an Avalon-MM slave. Sits inside the Qsys system next to the LED debug PIO and replaces the fixed-width, fixed-window counter.

## Interface
- N_CH, 6, number of measured channels (1..8)
- GATE_CYCLES, 125000000, gate window length in clk cycles (≥ 4)
- CNT_W, 32, per-channel count width (≤ 32)
- SYNC_STAGES, 2, synchroniser depth per channel (≥ 2)

- clk  in  1  system clock (125 MHz); sole clock of the block
- reset  in  1  synchronous, active-high reset
- meas_in  in  N_CH  asynchronous clock indicators; each must toggle at < clk/2.5
- avs_address  in  5  word address
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data
- avs_readdatavalid  out  1  read data valid
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- led_dbg  out  1  toggles at each gate end

## Operation
- Per channel: SYNC_STAGES flop synchroniser, then 1-flop edge detector; rise = sync & ~sync_d.
- Gate counter runs 0..GATE_CYCLES-1 while CTRL.enable=1; gate_end asserted on the cycle it equals GATE_CYCLES-1, then wraps to 0.
- Channel counters increment on rise; saturate at 2^CNT_W-1, never wrap.
- On gate_end: result[ch] <= cnt[ch] + rise[ch] (saturating); cnt[ch] <= 0; alive[ch] <= (loaded result ≠ 0); valid <= 1; gate_seq += 1 (32-bit, wraps); led_dbg inverts.
- CTRL.enable=0: gate and channel counters held at 0; results, alive, valid, gate_seq retained. Enable 0→1 starts a full fresh window.
- Register map (word addr): 0 ID = 0x434C4B4D; 1 CTRL (bit0 enable RW, reset 1; bit1 clear_minmax W1, self-clearing, reads 0); 2 STATUS (bits[N_CH-1:0] alive, bit31 valid); 3 GATE_CYCLES (RO); 4 gate_seq (RO); 8+ch result[ch], zero-extended to 32. Unmapped or ch ≥ N_CH reads 0. Writes to non-CTRL addresses ignored.
- Reset values: all counters, results, gate_seq, alive, valid, led_dbg, avs_readdata, avs_readdatavalid = 0; CTRL.enable = 1.

## Timing
- Read latency fixed 1: avs_readdatavalid pulses the cycle after avs_read; avs_readdata held until next read. No waitrequest; back-to-back reads each cycle accepted.
- Read on the same cycle as gate_end returns the pre-update value.
- Write takes effect on the cycle after avs_write; read and write in same cycle: write wins, read returns old value.
- meas_in edge to counter increment: SYNC_STAGES+1 cycles; edges within that latency of gate_end fall into the next window (±1 count uncertainty accepted).
- reset asserted mid-window: all state to reset values next cycle; window restarts from 0 after release.

## Configuration
- CLK_MEAS_MULTI_MINMAX_EN defined: per-channel min[ch]/max[ch] registers at 16+ch / 24+ch, updated with each loaded result (min reset 2^CNT_W-1, max reset 0); CTRL.clear_minmax restores those reset values the next cycle; clear coinciding with gate_end loads min=max=new result.
- Undefined: no min/max storage, addresses 16..31 read 0, clear_minmax has no effect.

## Test plan
- GATE_CYCLES=1000, ch0 toggling with period 10 clk -> after 2nd gate_end result[0]=100, STATUS alive bit0=1, valid=1, gate_seq=2.
- ch1 held low, ch2 period 4 clk -> result[1]=0 with alive bit1=0; result[2]=250.
- CNT_W=8, ch0 period 3 clk, GATE_CYCLES=1000 -> result[0]=255 (saturated), no wrap.
- Write CTRL=0 mid-window, wait 3000 cycles, write CTRL=1 -> gate_seq unchanged while disabled; next result equals full-window count, not partial.
- Synchronous reset asserted 500 cycles into window -> all registers read reset values; ID read returns 0x434C4B4D with readdatavalid exactly 1 cycle after read.
- MINMAX_EN: ch0 period alternated 10/20 clk across gates -> min=50, max=100 (GATE_CYCLES=1000); clear_minmax -> min=0xFFFFFFFF, max=0 until next gate.

Source files
------------

// File: rtl/clk_meas_multi.sv
// clk_meas_multi -- multi-channel reference-clock frequency meter.
//
// Counts rising edges on N_CH asynchronous clock-indicator inputs over a
// gate window of GATE_CYCLES clk cycles and publishes per-channel counts
// through an Avalon-MM slave (fixed read latency 1, no waitrequest).
//
// Optional feature: define CLK_MEAS_MULTI_MINMAX_EN to add per-channel
// min/max result tracking (word addresses 16+ch / 24+ch, cleared by
// CTRL.clear_minmax). Without it those addresses read 0.
//
// Ports:
//   clk               system clock, sole clock of the block
//   reset             synchronous, active-high
//   meas_in           [N_CH] asynchronous clock indicators
//   avs_address       [5] word address
//   avs_read          read strobe, data returned next cycle
//   avs_readdata      [32] read data, held until next read
//   avs_readdatavalid read data valid pulse
//   avs_write         write strobe (only CTRL is writable)
//   avs_writedata     [32] write data
//   led_dbg           toggles at each gate end
//
// Register map (word address):
//   0 ID 0x434C4B4D | 1 CTRL (b0 enable, b1 clear_minmax W1) |
//   2 STATUS (alive[N_CH-1:0], b31 valid) | 3 GATE_CYCLES | 4 gate_seq |
//   8+ch result[ch] | 16+ch min[ch] | 24+ch max[ch]

// Per-channel lane: synchroniser, edge detector, saturating window counter,
// latched result and optional min/max.
module clk_meas_lane #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             gate_end,
  input  logic             meas,
  output logic [CNT_W-1:0] result,
  output logic             alive
`ifdef CLK_MEAS_MULTI_MINMAX_EN
  ,
  input  logic             clear_mm,
  output logic [CNT_W-1:0] min_val,
  output logic [CNT_W-1:0] max_val
`endif
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_fin;

  assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;
  // Count including this cycle's edge, pinned at all-ones.
  assign cnt_fin = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(rise);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      sync_d <= 1'b0;
      cnt    <= '0;
      result <= '0;
      alive  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], meas};
      sync_d <= sync_q[SYNC_STAGES-1];
      if (!enable) begin
        cnt <= '0;
      end else if (gate_end) begin
        cnt    <= '0;
        result <= cnt_fin;
        alive  <= |cnt_fin;
      end else begin
        cnt <= cnt_fin;
      end
    end
  end

`ifdef CLK_MEAS_MULTI_MINMAX_EN
  // A clear landing on gate_end discards history, so the new result becomes
  // both min and max.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_val <= '1;
      max_val <= '0;
    end else if (gate_end) begin
      min_val <= (clear_mm || cnt_fin < min_val) ? cnt_fin : min_val;
      max_val <= (clear_mm || cnt_fin > max_val) ? cnt_fin : max_val;
    end else if (clear_mm) begin
      min_val <= '1;
      max_val <= '0;
    end
  end
`endif
endmodule

module clk_meas_multi #(
  parameter int N_CH        = 6,
  parameter int GATE_CYCLES = 125000000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] meas_in,
  input  logic [4:0]      avs_address,
  input  logic            avs_read,
  output logic [31:0]     avs_readdata,
  output logic            avs_readdatavalid,
  input  logic            avs_write,
  input  logic [31:0]     avs_writedata,
  output logic            led_dbg
);
  localparam int          GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [31:0] ID_VAL    = 32'h434C4B4D;

  logic [GW-1:0]                gate_cnt;
  logic                         enable;
  logic                         gate_end;
  logic                         valid;
  logic [31:0]                  gate_seq;
  logic                         ctrl_wr;
  logic [31:0]                  rd_mux;
  logic [N_CH-1:0]              alive;
  logic [N_CH-1:0][CNT_W-1:0]   result;

  assign gate_end = enable && (gate_cnt == GATE_LAST);
  assign ctrl_wr  = avs_write && (avs_address == 5'd1);

`ifdef CLK_MEAS_MULTI_MINMAX_EN
  logic                         clear_mm;
  logic [N_CH-1:0][CNT_W-1:0]   min_val;
  logic [N_CH-1:0][CNT_W-1:0]   max_val;
  logic                         unused_wdata;
  // Clear acts on the write cycle so min/max read reset values next cycle.
  assign clear_mm     = ctrl_wr && avs_writedata[1];
  assign unused_wdata = &{1'b0, avs_writedata[31:2]};
`else
  logic                         unused_wdata;
  assign unused_wdata = &{1'b0, avs_writedata[31:1]};
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    clk_meas_lane #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .gate_end (gate_end),
      .meas     (meas_in[c]),
      .result   (result[c]),
      .alive    (alive[c])
`ifdef CLK_MEAS_MULTI_MINMAX_EN
      ,
      .clear_mm (clear_mm),
      .min_val  (min_val[c]),
      .max_val  (max_val[c])
`endif
    );
  end

  // Read mux sees pre-update state, so a read on gate_end or alongside a
  // write returns the old value.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      5'd0: rd_mux = ID_VAL;
      5'd1: rd_mux = {31'd0, enable};
      5'd2: begin
        rd_mux[N_CH-1:0] = alive;
        rd_mux[31]       = valid;
      end
      5'd3: rd_mux = 32'(GATE_CYCLES);
      5'd4: rd_mux = gate_seq;
      default: ;
    endcase
    for (int c = 0; c < N_CH; c++) begin
      if (avs_address == 5'(8 + c))  rd_mux = 32'(result[c]);
`ifdef CLK_MEAS_MULTI_MINMAX_EN
      if (avs_address == 5'(16 + c)) rd_mux = 32'(min_val[c]);
      if (avs_address == 5'(24 + c)) rd_mux = 32'(max_val[c]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_cnt          <= '0;
      enable            <= 1'b1;
      valid             <= 1'b0;
      gate_seq          <= '0;
      led_dbg           <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      if (!enable || gate_end) gate_cnt <= '0;
      else                     gate_cnt <= gate_cnt + GW'(1);
      if (gate_end) begin
        valid    <= 1'b1;
        gate_seq <= gate_seq + 32'd1;
        led_dbg  <= ~led_dbg;
      end
      if (ctrl_wr) enable <= avs_writedata[0];
      avs_readdatavalid <= avs_read;
      if (avs_read) avs_readdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_clk_meas_multi.sv
module tb_clk_meas_multi;
  localparam int N_CH  = 6;
  localparam int GATE  = 1000;
  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] meas_in;
  logic [4:0]      avs_address;
  logic            avs_read, avs_write;
  logic [31:0]     avs_writedata, avs_readdata;
  logic            avs_readdatavalid, led_dbg;

  always #4 clk = ~clk;

  clk_meas_multi #(
    .N_CH(N_CH), .GATE_CYCLES(GATE), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .meas_in(meas_in),
    .avs_address(avs_address), .avs_read(avs_read),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .led_dbg(led_dbg)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int due; int addr; } exp_t;
  exp_t q[$];

  // Reference model: unbounded per-window edge totals, saturated on load.
  bit              m_en, m_valid, m_led;
  int              m_pos;
  longint          m_acc[N_CH], m_res[N_CH], m_mn[N_CH], m_mx[N_CH];
  bit [N_CH-1:0]   m_alive, m_lvl;
  logic [31:0]     m_seq;
  logic [N_CH-1:0] rq[$];   // edge events in flight through the synchroniser
  int per[N_CH], ph[N_CH];
  int plist[7] = '{0, 3, 4, 5, 7, 10, 20};

  function automatic logic [31:0] mread(input int a);
    if (a == 0) return 32'h434C4B4D;
    if (a == 1) return {31'd0, m_en};
    if (a == 2) return {m_valid, 31'(m_alive)};
    if (a == 3) return GATE;
    if (a == 4) return m_seq;
    if (a >= 8 && a < 8 + N_CH) return 32'(m_res[a-8]);
`ifdef CLK_MEAS_MULTI_MINMAX_EN
    if (a >= 16 && a < 16 + N_CH) return 32'(m_mn[a-16]);
    if (a >= 24 && a < 24 + N_CH) return 32'(m_mx[a-24]);
`endif
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_en = 1; m_pos = 0; m_valid = 0; m_led = 0; m_seq = 0;
    m_alive = '0; m_lvl = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_acc[c] = 0; m_res[c] = 0; m_mn[c] = CMAX; m_mx[c] = 0;
    end
    rq.delete();
    repeat (SYNC) rq.push_back('0);
  endtask

  task automatic model_step(input bit r, input bit rd, input int a,
                            input bit wr, input logic [31:0] wd,
                            input logic [N_CH-1:0] lv);
    logic [N_CH-1:0] cr;
    exp_t e;
    longint t;
    if (r) begin model_reset(); return; end
    if (rd) begin
      e.data = mread(a); e.due = cyc + 1; e.addr = a;
      q.push_back(e);
    end
    cr = rq.pop_front();
`ifdef CLK_MEAS_MULTI_MINMAX_EN
    if (wr && a == 1 && wd[1])
      for (int c = 0; c < N_CH; c++) begin m_mn[c] = CMAX; m_mx[c] = 0; end
`endif
    if (m_en) begin
      if (m_pos == GATE - 1) begin
        for (int c = 0; c < N_CH; c++) begin
          t = m_acc[c] + longint'(cr[c]);
          m_res[c] = (t > CMAX) ? CMAX : t;
          m_alive[c] = (m_res[c] != 0);
          if (m_res[c] < m_mn[c]) m_mn[c] = m_res[c];
          if (m_res[c] > m_mx[c]) m_mx[c] = m_res[c];
          m_acc[c] = 0;
        end
        m_valid = 1; m_seq = m_seq + 1; m_led = ~m_led; m_pos = 0;
      end else begin
        for (int c = 0; c < N_CH; c++) m_acc[c] += longint'(cr[c]);
        m_pos++;
      end
    end else begin
      m_pos = 0;
      for (int c = 0; c < N_CH; c++) m_acc[c] = 0;
    end
    if (wr && a == 1) m_en = wd[0];
    rq.push_back(lv & ~m_lvl);
    m_lvl = lv;
  endtask

  // One clock of stimulus: inputs change on the falling edge, model steps
  // for the rising edge that will sample them.
  task automatic step(input bit r, input bit rd, input int a, input bit wr,
                      input logic [31:0] wd);
    logic [N_CH-1:0] lv;
    @(negedge clk);
    for (int c = 0; c < N_CH; c++) begin
      lv[c] = (per[c] != 0) && (ph[c] < per[c] / 2);
      ph[c] = (per[c] == 0) ? 0 : (ph[c] + 1) % per[c];
    end
    reset = r; avs_read = rd; avs_address = 5'(a);
    avs_write = wr; avs_writedata = wd; meas_in = lv;
    model_step(r, rd, a, wr, wd, lv);
  endtask

  task automatic run_rand(input int n, input bit wild);
    for (int i = 0; i < n; i++) begin
      bit rd, wr, r;
      int a;
      logic [31:0] wd;
      rd = ($urandom_range(0, 3) == 0);
      a  = $urandom_range(0, 31);
      wr = 0; wd = $urandom; r = 0;
      if (wild) begin
        if ($urandom_range(0, 99) == 0) wr = 1;
        if (wr && $urandom_range(0, 1) == 0) begin
          a = 1;
          wd = {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0)};
        end
        if ($urandom_range(0, 2999) == 0) r = 1;
      end
      step(r, rd, a, wr, wd);
    end
  endtask

  task automatic read_list(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) step(0, 1, a, 0, 0);
  endtask

  // Monitor: every cycle check led_dbg and match returned reads to the queue.
  initial forever begin
    @(posedge clk); #1;
    checks++;
    if (led_dbg !== m_led) begin
      errors++;
      $display("FAIL led_dbg cyc=%0d got=%b exp=%b", cyc, led_dbg, m_led);
    end
    if (avs_readdatavalid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_readdatavalid cyc=%0d got=1 exp=0", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (avs_readdata !== e.data || e.due != cyc) begin
          errors++;
          $display("FAIL read addr=%0d cyc=%0d got=%h exp=%h due=%0d",
                   e.addr, cyc, avs_readdata, e.data, e.due);
        end
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++; errors++;
      $display("FAIL missing_readdatavalid addr=%0d cyc=%0d got=0 exp=1", e.addr, cyc);
    end
  end

  initial begin
    reset = 1; meas_in = '0; avs_address = '0; avs_read = 0;
    avs_write = 0; avs_writedata = '0;
    for (int c = 0; c < N_CH; c++) begin per[c] = 0; ph[c] = 0; end
    model_reset();
    repeat (3) step(1, 0, 0, 0, 0);
    read_list(0, 31);                          // reset state of every address

    per = '{10, 0, 4, 3, 7, 5};                // ch3 saturates at CNT_W=8
    run_rand(2 * GATE + 50, 0);
    read_list(8, 8 + N_CH - 1); read_list(2, 4);

    step(0, 0, 1, 1, 32'd0);                   // disable mid-window
    run_rand(3000, 0);
    step(0, 1, 1, 1, 32'd1);                   // read+write same cycle
    run_rand(GATE + 20, 0);
    read_list(2, 4); read_list(8, 8 + N_CH - 1);

    run_rand(500, 0);
    step(1, 0, 0, 0, 0);                       // reset mid-window
    read_list(0, 31);

    for (int g = 0; g < 4; g++) begin          // ch0 alternates 10/20
      per[0] = (g % 2) ? 20 : 10;
      run_rand(GATE, 0);
    end
    read_list(16, 31);
    step(0, 0, 1, 1, 32'd3);                   // clear_minmax, keep enable
    read_list(16, 31);

    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < N_CH; c++) per[c] = plist[$urandom_range(0, 6)];
      run_rand($urandom_range(600, 1500), 1);
      step(0, 0, 1, 1, 32'd1);
      read_list(8, 8 + N_CH - 1);
    end
    read_list(0, 31);
    repeat (5) step(0, 0, 0, 0, 0);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads got=%0d exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
